// File: rtl/text_cursor_writer.sv
// Cursor tracking and write issue between the character FIFO and the text buffer.
// Decodes printable characters and CR/LF/BS/FF, and paces single-cycle writes on buffer_busy.
module text_cursor_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [6:0] char_data,
  output logic       char_ready,
  input  logic       buffer_busy,
  output logic       write_enable,
  output logic [6:0] write_x,
  output logic [4:0] write_y,
  output logic [6:0] write_data,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       clearing
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_DECODE       = 3'd1;
  localparam logic [2:0] S_ISSUE        = 3'd2;
  localparam logic [2:0] S_GAP          = 3'd3;
  localparam logic [2:0] S_CLEAR_ROW    = 3'd4;
  localparam logic [2:0] S_CLEAR_SCREEN = 3'd5;

  localparam logic [6:0]  X_MAX         = 7'(COLS - 1);
  localparam logic [4:0]  Y_MAX         = 5'(ROWS - 1);
  localparam logic [11:0] ROW_WRITES    = 12'(COLS);
  localparam logic [11:0] SCREEN_WRITES = 12'(COLS * ROWS);

  localparam logic [1:0] CLR_NONE   = 2'd0;
  localparam logic [1:0] CLR_ROW    = 2'd1;
  localparam logic [1:0] CLR_SCREEN = 2'd2;

  logic [2:0]  state;
  logic [6:0]  char_q;
  logic [6:0]  next_x;
  logic [4:0]  next_y;
  logic        row_after;
  logic [11:0] clr_cnt;
  logic [1:0]  clear_mode;
  logic        issuing;
  logic        clr_done;

  function automatic logic [4:0] row_inc(input logic [4:0] y);
    return (y == Y_MAX) ? 5'd0 : y + 5'd1;
  endfunction

  // Strobe, ready and clear-status decode; ready is forced low while reset is held.
  always_comb begin
    issuing      = (state == S_ISSUE) || (state == S_CLEAR_ROW) || (state == S_CLEAR_SCREEN);
    write_enable = issuing && !buffer_busy;
    char_ready   = (state == S_IDLE) && !reset;
    clearing     = (clear_mode != CLR_NONE);
    if (clear_mode == CLR_SCREEN) begin
      clr_done = (clr_cnt == SCREEN_WRITES);
    end else begin
      clr_done = (clr_cnt == ROW_WRITES);
    end
  end

  // Control FSM, cursor and registered write command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      char_q     <= 7'd0;
      next_x     <= 7'd0;
      next_y     <= 5'd0;
      row_after  <= 1'b0;
      clr_cnt    <= 12'd0;
      clear_mode <= CLR_NONE;
      write_x    <= 7'd0;
      write_y    <= 5'd0;
      write_data <= 7'd0;
      cursor_x   <= 7'd0;
      cursor_y   <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (char_valid) begin
            char_q <= char_data;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (char_q >= 7'h20 && char_q != 7'h7F) begin
            write_x    <= cursor_x;
            write_y    <= cursor_y;
            write_data <= char_q;
            if (cursor_x == X_MAX) begin
              next_x    <= 7'd0;
              next_y    <= row_inc(cursor_y);
              row_after <= 1'b1;
            end else begin
              next_x    <= cursor_x + 7'd1;
              next_y    <= cursor_y;
              row_after <= 1'b0;
            end
            state <= S_ISSUE;
          end else begin
            case (char_q)
              7'h0D: begin
                cursor_x <= 7'd0;
                state    <= S_IDLE;
              end
              7'h0A: begin
                cursor_y   <= row_inc(cursor_y);
                write_x    <= 7'd0;
                write_y    <= row_inc(cursor_y);
                write_data <= BLANK;
                clr_cnt    <= 12'd0;
                clear_mode <= CLR_ROW;
                state      <= S_CLEAR_ROW;
              end
              7'h08: begin
                row_after <= 1'b0;
                if (cursor_x != 7'd0) begin
                  next_x     <= cursor_x - 7'd1;
                  next_y     <= cursor_y;
                  write_x    <= cursor_x - 7'd1;
                  write_y    <= cursor_y;
                  write_data <= BLANK;
                  state      <= S_ISSUE;
                end else if (cursor_y != 5'd0) begin
                  next_x     <= X_MAX;
                  next_y     <= cursor_y - 5'd1;
                  write_x    <= X_MAX;
                  write_y    <= cursor_y - 5'd1;
                  write_data <= BLANK;
                  state      <= S_ISSUE;
                end else begin
                  state <= S_IDLE;
                end
              end
              7'h0C: begin
                write_x    <= 7'd0;
                write_y    <= 5'd0;
                write_data <= BLANK;
                clr_cnt    <= 12'd0;
                clear_mode <= CLR_SCREEN;
                state      <= S_CLEAR_SCREEN;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_ISSUE: begin
          if (!buffer_busy) begin
            cursor_x <= next_x;
            cursor_y <= next_y;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          if (clear_mode == CLR_NONE) begin
            // A wrap from the last column blanks the row the cursor just landed on.
            if (row_after) begin
              row_after  <= 1'b0;
              write_x    <= 7'd0;
              write_y    <= cursor_y;
              write_data <= BLANK;
              clr_cnt    <= 12'd0;
              clear_mode <= CLR_ROW;
              state      <= S_CLEAR_ROW;
            end else begin
              state <= S_IDLE;
            end
          end else if (clr_done) begin
            clear_mode <= CLR_NONE;
            state      <= S_IDLE;
          end else begin
            if (clear_mode == CLR_SCREEN && write_x == X_MAX) begin
              write_x <= 7'd0;
              write_y <= write_y + 5'd1;
            end else begin
              write_x <= write_x + 7'd1;
            end
            state <= (clear_mode == CLR_SCREEN) ? S_CLEAR_SCREEN : S_CLEAR_ROW;
          end
        end
        S_CLEAR_ROW: begin
          if (!buffer_busy) begin
            clr_cnt <= clr_cnt + 12'd1;
            state   <= S_GAP;
          end
        end
        S_CLEAR_SCREEN: begin
          if (!buffer_busy) begin
            clr_cnt <= clr_cnt + 12'd1;
            state   <= S_GAP;
            if (clr_cnt == SCREEN_WRITES - 12'd1) begin
              cursor_x <= 7'd0;
              cursor_y <= 5'd0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/text_cursor_writer.md
# text_cursor_writer

Cursor-management and write-issue stage between the character FIFO and `TextDisplayWithBuffer`. It consumes 7-bit ASCII characters over a valid/ready handshake and tracks the 80x30 cursor. It interprets control codes (CR, LF, BS, FF), handles line wrap and row blanking, and issues single-cycle buffer write commands paced by the buffer's `busy` signal.

## Interface
- `COLS`, 80: columns per row; x range 0..COLS-1.
- `ROWS`, 30: rows per screen; y range 0..ROWS-1.
- `BLANK`, 7'h20: character written when blanking cells.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `char_valid` in 1: `char_data` is valid.
- `char_data` in 7: ASCII character.
- `char_ready` out 1: block accepts a character this cycle. Transfer occurs when `char_valid && char_ready`.
- `buffer_busy` in 1: text buffer cannot take a write.
- `write_enable` out 1: one-cycle write strobe to the buffer.
- `write_x` out 7: column of the write.
- `write_y` out 5: row of the write.
- `write_data` out 7: character to write.
- `cursor_x` out 7: current cursor column.
- `cursor_y` out 5: current cursor row.
- `clearing` out 1: high while a row or screen blank is in progress.

## Operation
- States:
  - IDLE: `char_ready`=1.
  - DECODE: one cycle.
  - ISSUE: wait for `!buffer_busy`, then pulse `write_enable`.
  - GAP: one cycle after each pulse.
  - CLEAR_ROW: 80 blank writes.
  - CLEAR_SCREEN: COLS*ROWS blank writes, row-major from (0,0).
- Character decode, taken in DECODE:
  - Printable 0x20..0x7E: write at (cursor_x, cursor_y), then advance x. At x=COLS-1 the advance sets x=0 and moves to the next row, then runs CLEAR_ROW on that row.
  - 0x0D CR: x=0. No write. Back to IDLE.
  - 0x0A LF: y = y+1, wrapping ROWS-1 to 0. x is unchanged. Then CLEAR_ROW on the new row.
  - 0x08 BS:
    - x>0: x = x-1, then write BLANK at the new position.
    - x=0 and y>0: x=COLS-1, y = y-1, then write BLANK.
    - At (0,0): no-op.
  - 0x0C FF: CLEAR_SCREEN, then cursor to (0,0).
  - Any other code below 0x20, and 0x7F: discarded. No cursor change.
- Row advance: from ROWS-1 the row always wraps to 0. There is no scrolling.
- Blanking writes BLANK to x=0..COLS-1 of the target row. The cursor holds its post-advance value throughout.
- `write_x`, `write_y` and `write_data` are registered. They are stable in the cycle `write_enable`=1 and hold their last value otherwise.
- Arithmetic: x and y are unsigned. Comparisons use `COLS-1` and `ROWS-1`. The clear counter is 12 bits wide, enough to cover 2400.

## Timing
- Reset: asynchronous assert. All outputs are 0 while `reset`=1, including `char_ready`. The state goes to IDLE and the cursor to (0,0). `char_ready`=1 in the first cycle after deassert.
- Reset mid-operation: any pending or clearing writes are abandoned immediately. No further `write_enable` is issued.
- Acceptance:
  - A character accepted at edge N enters DECODE at N+1.
  - The earliest `write_enable` is in cycle N+2, provided `buffer_busy`=0 in that cycle.
  - `buffer_busy` is sampled combinationally in ISSUE. No pulse is issued while it is high.
- Each write is followed by GAP, so the minimum spacing is 2 cycles per write.
  - A single printable char, buffer idle: accepted at N, write in cycle N+2, `char_ready`=1 again in cycle N+4.
  - Row clear: 160 cycles minimum.
  - Screen clear: 4800 cycles minimum.
- Cursor update: `cursor_x`/`cursor_y` update on the edge ending the final cursor-moving write. For CR and LF the update happens on the DECODE edge.
- `clearing` is high from the first blank write through the GAP after the last one.
- `char_ready`=0 in every state except IDLE. Characters are never dropped while `char_valid` is held.

## Test plan
- Reset, then send 'A' (0x41) with `buffer_busy`=0 -> one `write_enable` at (0,0) with data 0x41. Cursor then reads (1,0). `char_ready` returns high 4 cycles after acceptance.
- Hold `buffer_busy`=1 for 10 cycles after accepting 'B' -> no strobe during those cycles. Exactly one strobe occurs in the first cycle `busy` is low, with data 0x42.
- With cursor at (79,29), send 'Z' -> write at (79,29). Cursor wraps to (0,0). 80 BLANK writes follow on row 0, with `clearing` high throughout.
- Type "HI" then BS, BS, BS -> two blank writes at (1,0) and (0,0). The third BS is a no-op with no write. Cursor ends at (0,0).
- Cursor at (5,3): send CR then LF -> cursor (0,3) with no write, then (0,4). 80 blank writes follow on row 4.
- Send FF, then assert `reset` after 100 writes -> `write_enable` stops immediately. All outputs read 0. `char_ready`=1 one cycle after deassert.
